// File: rtl/lgdst_ts_serializer.sv
// Generic byte FIFO: count-based full/empty, pointers wrap modulo DEPTH (power of 2).
// Latency 1 cycle push-to-visible; push ignored when full, pop ignored when empty.
// Backpressure: producer must honour full.
module lgdst_byte_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Aligns SPI bytes to 188-byte TS packets on 0x47 and serializes them MSB-first on a divided ts_clk.
// Latency: byte shows on ts_d0 at the first ts_clk fall event after it is queued (<= 1+2*CLK_DIV clk).
// Backpressure: in_ready is registered and drops while the byte FIFO is full.
module lgdst_ts_serializer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 2,
  parameter int PKT_LEN    = 188
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ts_clk,
  output logic       ts_valid,
  output logic       ts_sync,
  output logic       ts_d0,
  output logic       locked,
  output logic       sync_err
);
  localparam int IW = $clog2(PKT_LEN);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  logic [0:0]    state;
  logic [IW-1:0] byte_idx;
  logic          started;
  logic          xfer, is_sync, bad_sync, push, sof;
  logic          fifo_full, fifo_empty, pop;
  logic [8:0]    pop_dat;
  logic [DW-1:0] div_cnt;
  logic          div_wrap, fall_evt;
  logic [2:0]    bit_cnt;
  logic [6:0]    shreg;

  // started keeps in_ready low until the first edge after reset release
  assign in_ready = started & ~fifo_full;
  assign xfer     = in_valid & in_ready;
  assign is_sync  = (in_data == SYNC_BYTE);
  assign bad_sync = (state == ST_LOCK) && (byte_idx == '0) && !is_sync;
  assign sof      = (state == ST_HUNT) || (byte_idx == '0);
  assign push     = xfer && ((state == ST_HUNT) ? is_sync : !bad_sync);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started  <= 1'b0;
      state    <= ST_HUNT;
      byte_idx <= '0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      started  <= 1'b1;
      sync_err <= 1'b0;
      if (xfer) begin
        if (state == ST_HUNT) begin
          if (is_sync) begin
            state    <= ST_LOCK;
            locked   <= 1'b1;
            byte_idx <= IW'(1);
          end
        end else if (bad_sync) begin
          state    <= ST_HUNT;
          locked   <= 1'b0;
          sync_err <= 1'b1;
          byte_idx <= '0;
        end else begin
          byte_idx <= (byte_idx == IW'(PKT_LEN - 1)) ? '0 : byte_idx + 1'b1;
        end
      end
    end
  end

  lgdst_byte_fifo #(.W(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat ({sof, in_data}),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign div_wrap = (div_cnt == DW'(CLK_DIV - 1));
  assign fall_evt = div_wrap & ts_clk;
  assign pop      = fall_evt && (bit_cnt == 3'd0) && !fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      ts_clk  <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      ts_clk  <= ~ts_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // outputs move only on fall events so they are stable at each ts_clk rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= 3'd0;
      shreg    <= '0;
      ts_valid <= 1'b0;
      ts_sync  <= 1'b0;
      ts_d0    <= 1'b0;
    end else if (fall_evt) begin
      if (bit_cnt == 3'd0) begin
        if (!fifo_empty) begin
          ts_d0    <= pop_dat[7];
          shreg    <= pop_dat[6:0];
          ts_valid <= 1'b1;
          ts_sync  <= pop_dat[8];
          bit_cnt  <= 3'd7;
        end else begin
          ts_valid <= 1'b0;
          ts_sync  <= 1'b0;
          ts_d0    <= 1'b0;
        end
      end else begin
        ts_d0   <= shreg[6];
        shreg   <= {shreg[5:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lgdst_ts_serializer.sv
// Scoreboard bench: accepted bytes are modelled against packet alignment and compared with the serial output.
module tb_lgdst_ts_serializer;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, ts_clk, ts_valid, ts_sync, ts_d0, locked, sync_err;

  int n_total = 0;
  int n_bad   = 0;

  logic [8:0] sb [$];
  logic       m_lock = 1'b0;
  int         m_idx  = 0;

  int   mbits = 0;
  logic [7:0] mbyte;
  logic msync, prev_ts = 1'b0, prev_v = 1'b0, prev_err = 1'b0;
  int   n_rise = 0, n_bytes = 0, n_sof = 0, n_idle = 0, n_err = 0, n_stall = 0, n_vsamp = 0;
  logic gap_mon = 1'b0, seen_v = 1'b0;
  int   gaps = 0;

  always #5 clk = ~clk;

  lgdst_ts_serializer dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ts_clk   (ts_clk),
    .ts_valid (ts_valid),
    .ts_sync  (ts_sync),
    .ts_d0    (ts_d0),
    .locked   (locked),
    .sync_err (sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference alignment model: decides which accepted bytes must reach ts_d0.
  task automatic model_accept(input logic [7:0] b);
    if (!m_lock) begin
      if (b == 8'h47) begin
        sb.push_back({1'b1, b});
        m_lock = 1'b1;
        m_idx  = 1;
      end
    end else if (m_idx == 0 && b != 8'h47) begin
      m_lock = 1'b0;
    end else begin
      sb.push_back({m_idx == 0, b});
      m_idx = (m_idx == 187) ? 0 : m_idx + 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      model_accept(b);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt();
    send_byte(8'h47);
    for (int i = 0; i < 187; i++) send_byte(8'(i));
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || mbits != 0) && t < 40000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", sb.size(), 0);
    repeat (40) @(negedge clk);
  endtask

  // Output monitor: samples one bit per ts_clk rise, half a clk after it.
  always @(negedge clk) begin
    if (!reset) begin
      mbits   = 0;
      prev_ts = 1'b0;
      prev_v  = 1'b0;
    end else begin
      if (in_valid && !in_ready) n_stall++;
      if (ts_valid) n_vsamp++;
      if (ts_clk && !prev_ts) begin
        n_rise++;
        if (ts_valid) begin
          if (gap_mon) seen_v = 1'b1;
          if (mbits == 0) msync = ts_sync;
          else if (ts_sync !== msync) chk("sync_hold", {31'd0, ts_sync}, {31'd0, msync});
          mbyte = {mbyte[6:0], ts_d0};
          mbits++;
          if (mbits == 8) begin
            chk("byte_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
              logic [8:0] e;
              e = sb.pop_front();
              chk("byte_data", {24'd0, mbyte}, {24'd0, e[7:0]});
              chk("byte_sof", {31'd0, msync}, {31'd0, e[8]});
            end
            if (msync) n_sof++;
            n_bytes++;
            mbits = 0;
          end
        end else begin
          if (prev_v) begin
            chk("bits_contiguous", mbits, 0);
            chk("sync_when_idle", {31'd0, ts_sync}, 32'd0);
            mbits = 0;
          end
          n_idle++;
          if (gap_mon && seen_v && sb.size() > 0) gaps++;
        end
        prev_v = ts_valid;
      end
      prev_ts = ts_clk;
    end
    if (sync_err) begin
      n_err++;
      chk("sync_err_width", {31'd0, prev_err}, 32'd0);
    end
    prev_err = sync_err;
  end

  initial begin
    int h, r, p, b0, s0, i0, r0, v0, t;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    repeat (5) @(negedge clk);
    chk("reset_outputs", {25'd0, ts_clk, ts_valid, ts_sync, ts_d0, locked, sync_err, in_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
    chk("hunt_unlocked", {31'd0, locked}, 32'd0);
    h = 0; r = 0; p = ts_clk;
    repeat (40) begin
      @(negedge clk);
      h += ts_clk;
      if (ts_clk && !p) r++;
      p = ts_clk;
    end
    chk("tsclk_rises_40clk", r, 10);
    chk("tsclk_high_40clk", h, 20);

    // aligned stream of two packets, then a bad sync byte
    b0 = n_bytes; s0 = n_sof;
    send_byte(8'h47);
    chk("locked_first_byte", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 187; i++) send_byte(8'(i));
    send_pkt();
    chk("no_err_aligned", n_err, 0);
    send_byte(8'h48);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sync_err_pulse", {31'd0, sync_err}, 32'd1);
    chk("unlocked_on_err", {31'd0, locked}, 32'd0);
    @(negedge clk);
    chk("sync_err_clear", {31'd0, sync_err}, 32'd0);
    drain();
    chk("aligned_bytes", n_bytes - b0, 376);
    chk("aligned_sof", n_sof - s0, 2);

    // hunt junk, then three packets with in_valid held high
    b0 = n_bytes; s0 = n_sof; t = n_stall;
    gap_mon = 1'b1; seen_v = 1'b0; gaps = 0;
    send_byte(8'h12);
    send_byte(8'h34);
    chk("hunt_not_locked", {31'd0, locked}, 32'd0);
    send_byte(8'h47);
    chk("relocked", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 187; i++) send_byte(8'(i));
    send_pkt();
    send_pkt();
    drain();
    gap_mon = 1'b0;
    chk("bp_bytes", n_bytes - b0, 564);
    chk("bp_sof", n_sof - s0, 3);
    chk("bp_no_gaps", gaps, 0);
    chk("bp_stalled", {31'd0, n_stall > t}, 32'd1);

    // underflow: one byte every 100 clk
    b0 = n_bytes; i0 = n_idle; r0 = n_rise;
    for (int k = 0; k < 4; k++) begin
      send_byte((k == 0) ? 8'h47 : 8'(k));
      in_valid = 1'b0;
      repeat (100) @(negedge clk);
    end
    chk("uf_tsclk_running", {31'd0, (n_rise - r0) >= 90}, 32'd1);
    drain();
    chk("uf_bytes", n_bytes - b0, 4);
    chk("uf_idle_between", {31'd0, (n_idle - i0) > 40}, 32'd1);

    // reset in the middle of a byte
    send_byte(8'h04);
    send_byte(8'h05);
    in_valid = 1'b0;
    t = 0;
    while (mbits != 3 && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("reached_bit3", mbits, 3);
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {25'd0, ts_clk, ts_valid, ts_sync, ts_d0, locked, sync_err, in_ready}, 32'd0);
    sb.delete();
    m_lock = 1'b0;
    m_idx  = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("tsclk_restart_low", {31'd0, ts_clk}, 32'd0);
    v0 = n_vsamp;
    repeat (200) @(negedge clk);
    chk("fifo_empty_after_reset", n_vsamp - v0, 0);
    chk("ready_post_reset", {31'd0, in_ready}, 32'd1);
    chk("sync_err_total", n_err, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
